// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_unit_if                                                   |
// | Brief    : Instruction-memory read bus between the fetch unit (master) and |
// |            the instruction memory (slave).                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface fetch_unit_if;
  logic        imem_req;    // read request, held while fetch waits for data
  logic [31:0] imem_addr;   // read address (current pc)
  logic        imem_ready;  // imem_rdata valid this cycle
  logic [31:0] imem_rdata;  // instruction word returned by memory

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_unit                                                      |
// | Brief    : Single-outstanding instruction fetch stage. Requests the word   |
// |            at pc, registers it for the decoder, holds it until the         |
// |            downstream acknowledges, then steps pc by +4, a B/J offset or   |
// |            a JALR target.                                                  |
// | Options  : FETCH_MISALIGN_CHECK_EN - trap on a non word-aligned next pc    |
// |            (pc frozen, sticky misalign flag, fetch halted until reset).    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  // next-pc sources
  input  wire logic [31:0] imm_out,
  input  wire logic [31:0] alu_result,
  input  wire logic [1:0]  pc_src,
  // downstream handshake
  input  wire logic        inst_ack,
  input  wire logic        stall,
  // instruction memory bus
  fetch_unit_if.master     imem,
  // decoder side
  output logic [31:0]      inst,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             inst_valid,
  output logic             misalign
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // request outstanding, waiting for imem_ready
    S_HOLD = 2'd1,  // instruction presented, waiting for an un-stalled ack
    S_TRAP = 2'd2   // misaligned target seen, fetch halted until reset
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] next_pc;
  logic        advance;

  // Link value and the default sequential target; wraps modulo 2^32.
  assign pc_plus4 = pc_q + 32'd4;

  // A hold is released only by an ack that is not overridden by stall.
  assign advance = inst_ack && !stall;

  // Next-pc selection; the JALR target always has bit 0 cleared.
  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      2'b01:   next_pc = pc_q + imm_out;
      2'b10:   next_pc = {alu_result[31:1], 1'b0};
      default: next_pc = pc_plus4;
    endcase
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  logic target_misaligned;

  assign target_misaligned = (next_pc[1:0] != 2'b00);
`endif

  // Fetch sequencing: request -> capture -> hold until acked -> step pc.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_d   = misalign_q;
`endif
    case (state_q)
      S_REQ: begin
        if (imem.imem_ready) begin
          inst_d       = imem.imem_rdata;
          inst_valid_d = 1'b1;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (advance) begin
          inst_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
          if (target_misaligned) begin
            // pc keeps the address of the offending instruction
            misalign_d = 1'b1;
            state_d    = S_TRAP;
          end else begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end
`else
          pc_d    = next_pc;
          state_d = S_REQ;
`endif
        end
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // State registers; reset wins over every handshake input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      inst_q       <= 32'd0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Sticky misaligned-target flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = pc_q;
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign inst_valid     = inst_valid_q;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fetch_unit                                                   |
// | Brief    : Self-checking bench for fetch_unit: directed scenarios plus a   |
// |            randomized run against a transaction-level reference model.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit C_CHECK_EN = 1'b1;
`else
  localparam bit C_CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imm_out = '0;
  logic [31:0] alu_result = '0;
  logic [1:0]  pc_src = '0;
  logic        inst_ack = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(C_RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .imm_out    (imm_out),
    .alu_result (alu_result),
    .pc_src     (pc_src),
    .inst_ack   (inst_ack),
    .stall      (stall),
    .imem       (bus.master),
    .inst       (inst),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .inst_valid (inst_valid),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  // Reference model: one fetched word at a time, described by whether a word
  // is currently held, the address it came from, and whether fetch is halted.
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  bit          m_have;
  bit          m_halted;

  task automatic model_edge();
    logic [31:0] target;
    if (rst) begin
      m_pc = C_RESET_PC; m_inst = 32'd0; m_have = 0; m_halted = 0;
    end else if (m_halted) begin
      // nothing moves until reset
    end else if (!m_have) begin
      if (bus.imem_ready) begin
        m_inst = bus.imem_rdata;
        m_have = 1;
      end
    end else if (inst_ack && !stall) begin
      if (pc_src == 2'd1)      target = m_pc + imm_out;
      else if (pc_src == 2'd2) target = alu_result & 32'hFFFF_FFFE;
      else                     target = m_pc + 32'd4;
      m_have = 0;
      if (C_CHECK_EN && (target % 4 != 0)) m_halted = 1;
      else m_pc = target;
    end
  endtask

  // Advance one clock; inputs are stable at the edge, outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  // From a request state at an aligned target: fetch, then JALR to target.
  task automatic jump_to(input logic [31:0] target);
    bus.imem_ready = 1'b1; bus.imem_rdata = $urandom;
    tick();
    bus.imem_ready = 1'b0;
    pc_src = 2'd2; alu_result = target; inst_ack = 1'b1; stall = 1'b0;
    tick();
    inst_ack = 1'b0; pc_src = 2'd0;
  endtask

  task automatic test_reset();
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    rst = 1'b1;
    tick(); tick();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 00000000", pc); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 00000000", inst); end
    rst = 1'b0; bus.imem_ready = 1'b0;
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL reset_req got %b exp 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 00000000", bus.imem_addr); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign); end
  endtask

  task automatic test_sequential();
    logic [31:0] word;
    do_reset();
    stall = 1'b0; pc_src = 2'd0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr[%0d] got %h exp %h", i, bus.imem_addr, 32'(4 * i)); end
      checks++; if (pc_plus4 !== 32'(4 * i + 4)) begin errors++; $display("FAIL seq_pc4[%0d] got %h exp %h", i, pc_plus4, 32'(4 * i + 4)); end
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL seq_req[%0d] got %b exp 1", i, bus.imem_req); end
      word = $urandom;
      bus.imem_ready = 1'b1; bus.imem_rdata = word; inst_ack = 1'b1;
      tick();
      bus.imem_ready = 1'b0;
      checks++; if (inst_valid !== 1'b1 || inst !== word) begin errors++; $display("FAIL seq_inst[%0d] got %b/%h exp 1/%h", i, inst_valid, inst, word); end
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL seq_hold_req[%0d] got %b exp 0", i, bus.imem_req); end
      tick();
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL seq_drop[%0d] got %b exp 0", i, inst_valid); end
    end
    inst_ack = 1'b0;
  endtask

  task automatic test_branch();
    do_reset();
    jump_to(32'h20);
    bus.imem_ready = 1'b1; tick(); bus.imem_ready = 1'b0;
    imm_out = 32'hFFFF_FFEC; pc_src = 2'd1; inst_ack = 1'b1;
    tick();
    inst_ack = 1'b0;
    checks++; if (bus.imem_addr !== 32'h0000_000C) begin errors++; $display("FAIL branch_back got %h exp 0000000c", bus.imem_addr); end
    jump_to(32'h8);
    bus.imem_ready = 1'b1; tick(); bus.imem_ready = 1'b0;
    imm_out = 32'hFFFF_FFEC; pc_src = 2'd1; inst_ack = 1'b1;
    tick();
    inst_ack = 1'b0; pc_src = 2'd0;
    checks++; if (bus.imem_addr !== 32'hFFFF_FFF4) begin errors++; $display("FAIL branch_wrap got %h exp fffffff4", bus.imem_addr); end
    jump_to(32'hFFFF_FFFC);
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL pc4_wrap got %h exp 00000000", pc_plus4); end
  endtask

  task automatic test_jalr();
    do_reset();
    bus.imem_ready = 1'b1; tick(); bus.imem_ready = 1'b0;
    alu_result = 32'h0000_0101; pc_src = 2'd2; inst_ack = 1'b1;
    tick();
    inst_ack = 1'b0; pc_src = 2'd0;
    checks++; if (bus.imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL jalr_addr got %h exp 00000100", bus.imem_addr); end
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL jalr_req got %b exp 1", bus.imem_req); end
  endtask

  task automatic test_stall();
    logic [31:0] p0;
    do_reset();
    jump_to(32'h40);
    p0 = 32'h40;
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'h00A0_0293;
    tick();
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'h1234_5678;
    stall = 1'b1; inst_ack = 1'b1; pc_src = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (inst !== 32'h00A0_0293 || pc !== p0) begin errors++; $display("FAIL stall_hold[%0d] got %h@%h exp 00a00293@%h", i, inst, pc, p0); end
      checks++; if (inst_valid !== 1'b1 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_flags[%0d] got v=%b req=%b exp v=1 req=0", i, inst_valid, bus.imem_req); end
    end
    bus.imem_ready = 1'b0; stall = 1'b0;
    tick();
    inst_ack = 1'b0;
    checks++; if (pc !== p0 + 32'd4 || inst_valid !== 1'b0) begin errors++; $display("FAIL stall_release got %h/%b exp %h/0", pc, inst_valid, p0 + 32'd4); end
  endtask

  task automatic test_ignore();
    logic [31:0] word;
    do_reset();
    bus.imem_ready = 1'b0; inst_ack = 1'b1; stall = 1'b0; pc_src = 2'd1; imm_out = 32'h100;
    tick();
    checks++; if (pc !== C_RESET_PC || bus.imem_req !== 1'b1) begin errors++; $display("FAIL ack_in_req got %h/%b exp %h/1", pc, bus.imem_req, C_RESET_PC); end
    word = $urandom;
    bus.imem_ready = 1'b1; bus.imem_rdata = word; inst_ack = 1'b0;
    tick();
    bus.imem_rdata = ~word;
    tick();
    checks++; if (inst !== word) begin errors++; $display("FAIL ready_in_hold got %h exp %h", inst, word); end
    bus.imem_ready = 1'b0; pc_src = 2'd3; inst_ack = 1'b1;
    tick();
    inst_ack = 1'b0; pc_src = 2'd0;
    checks++; if (bus.imem_addr !== C_RESET_PC + 32'd4) begin errors++; $display("FAIL src11 got %h exp %h", bus.imem_addr, C_RESET_PC + 32'd4); end
  endtask

  task automatic test_misalign();
    do_reset();
    bus.imem_ready = 1'b1; tick(); bus.imem_ready = 1'b0;
    imm_out = 32'd6; pc_src = 2'd1; inst_ack = 1'b1;
    tick();
    inst_ack = 1'b0; pc_src = 2'd0;
    if (C_CHECK_EN) begin
      bus.imem_ready = 1'b1; tick(); tick(); bus.imem_ready = 1'b0;
      checks++; if (misalign !== 1'b1 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL trap_flags got mis=%b req=%b exp mis=1 req=0", misalign, bus.imem_req); end
      checks++; if (pc !== 32'h0 || inst_valid !== 1'b0) begin errors++; $display("FAIL trap_pc got %h/%b exp 00000000/0", pc, inst_valid); end
    end else begin
      checks++; if (bus.imem_addr !== 32'h6 || misalign !== 1'b0) begin errors++; $display("FAIL misalign_off got %h/%b exp 00000006/0", bus.imem_addr, misalign); end
    end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 79) == 0);
      bus.imem_ready = ($urandom_range(0, 2) != 0);
      bus.imem_rdata = $urandom;
      inst_ack       = ($urandom_range(0, 2) != 0);
      stall          = ($urandom_range(0, 3) == 0);
      pc_src         = 2'($urandom_range(0, 3));
      imm_out        = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      alu_result     = $urandom;
      tick();
      checks++; if (bus.imem_req !== (!m_have && !m_halted)) begin errors++; $display("FAIL rnd_req[%0d] got %b exp %b", i, bus.imem_req, !m_have && !m_halted); end
      checks++; if (pc !== m_pc || bus.imem_addr !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] got %h/%h exp %h", i, pc, bus.imem_addr, m_pc); end
      checks++; if (pc_plus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_pc4[%0d] got %h exp %h", i, pc_plus4, m_pc + 32'd4); end
      checks++; if (inst_valid !== m_have) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, inst_valid, m_have); end
      checks++; if (misalign !== m_halted) begin errors++; $display("FAIL rnd_misalign[%0d] got %b exp %b", i, misalign, m_halted); end
      if (m_have) begin
        checks++; if (inst !== m_inst) begin errors++; $display("FAIL rnd_inst[%0d] got %h exp %h", i, inst, m_inst); end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    test_reset();
    test_sequential();
    test_branch();
    test_jalr();
    test_stall();
    test_ignore();
    test_misalign();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port imm_out  input  32  sign-extended immediate from the immediate extender (B/J offset).
REQ-005 SHALL have port alu_result  input  32  JALR target from ALU.
REQ-006 SHALL have port pc_src  input  2  next-PC select: 00 pc+4, 01 pc+imm_out, 10 jalr target, 11 treated as 00.
REQ-007 SHALL have port inst_ack  input  1  downstream has consumed inst this cycle.
REQ-008 SHALL have port stall  input  1  hazard hold; overrides inst_ack.
REQ-009 SHALL have port imem_req  output  1  instruction memory read request.
REQ-010 SHALL have port imem_addr  output  32  read address, equals pc.
REQ-011 SHALL have port imem_ready  input  1  imem_rdata valid this cycle.
REQ-012 SHALL have port imem_rdata  input  32  instruction word from memory.
REQ-013 SHALL have port inst  output  32  registered instruction to decoder/immediate extender.
REQ-014 SHALL have port pc  output  32  address of inst.
REQ-015 SHALL have port pc_plus4  output  32  pc+4 (link value), combinational from pc.
REQ-016 SHALL have port inst_valid  output  1  inst/pc hold a fetched instruction.
REQ-017 SHALL have port misalign  output  1  sticky misaligned-target flag (see Configuration).

Function
REQ-018 SHALL implement FSM states S_REQ, S_HOLD, S_TRAP.
REQ-019 In S_REQ: imem_req=1, imem_addr=pc; on imem_ready, inst<=imem_rdata, inst_valid<=1, go S_HOLD next edge; otherwise remain in S_REQ.
REQ-020 Minimum latency SHALL be imem_ready cycle -> inst_valid high next cycle; throughput at most one instruction per 2 cycles.
REQ-021 In S_HOLD: imem_req=0; inst, pc, inst_valid SHALL remain stable while stall=1 or inst_ack=0.
REQ-022 In S_HOLD with inst_ack=1 and stall=0: pc<=next_pc, inst_valid<=0, go S_REQ.
REQ-023 next_pc SHALL be pc+4, pc+imm_out, or {alu_result[31:1],1'b0} per pc_src, sampled in the ack cycle.
REQ-024 All PC arithmetic SHALL be 32-bit modulo 2^32 (wrap-around, no carry out).
REQ-025 imem_ready SHALL be ignored outside S_REQ; inst_ack SHALL be ignored outside S_HOLD.
REQ-026 stall and inst_ack high together SHALL be treated as stall (hold).
REQ-027 pc_plus4 SHALL track pc combinationally in all states.

Reset
REQ-028 On rst=1 at a clock edge: pc<=RESET_PC, inst<=0, inst_valid<=0, misalign<=0, state<=S_REQ.
REQ-029 rst SHALL take priority over imem_ready, inst_ack and stall; read data arriving in the reset cycle SHALL be discarded.
REQ-030 First request after reset SHALL assert imem_req in the first cycle with rst=0, imem_addr=RESET_PC.

Configuration
REQ-031 Macro FETCH_MISALIGN_CHECK_EN: when defined, an ack with next_pc[1:0]!=0 SHALL leave pc unchanged, set misalign=1 (sticky until reset), drop inst_valid, enter S_TRAP with imem_req=0 until reset.
REQ-032 Without FETCH_MISALIGN_CHECK_EN: misalign SHALL be tied 0, S_TRAP unreachable, next_pc loaded unchecked.

Verification
REQ-033 Reset: rst high 2 cycles, RESET_PC=0 -> pc=0, inst_valid=0; first cycle after release imem_req=1, imem_addr=0.
REQ-034 Sequential: imem_ready=1 each request, pc_src=00, ack each valid -> imem_addr 0,4,8; pc_plus4 4,8,12.
REQ-035 Branch backward: pc=32'h20, imm_out=32'hFFFF_FFEC, pc_src=01, ack -> next imem_addr=32'h0C; pc=32'h8 same imm -> 32'hFFFF_FFF4 (wrap).
REQ-036 JALR: alu_result=32'h0000_0101, pc_src=10, ack -> imem_addr=32'h100.
REQ-037 Stall: valid inst 32'h00A00293, stall=1 and inst_ack=1 for 3 cycles -> inst, pc unchanged, inst_valid=1, imem_req=0; release stall -> pc advances.
REQ-038 Misalign: pc=0, imm_out=6, pc_src=01, ack -> with macro misalign=1, imem_req stays 0, pc=0; without macro imem_addr=6, misalign=0.
